// File: rtl/sram_bridge_pkg.sv
// Shared definitions for the Wishbone / SRAM bridge.
// Holds the SRAM macro geometry, the port-1 read latency and the
// state types of the two port FSMs.
package sram_bridge_pkg;

  localparam int SRAM_ADDR_W     = 9;
  localparam int SRAM_DATA_W     = 32;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_W / 8;
  localparam int SRAM_DEPTH      = 1 << SRAM_ADDR_W;
  // Cycles from a port-1 issue until its word is visible at the FIFO output.
  localparam int RD_LAT          = 2;

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} p0_state_t;
  typedef enum logic       {S_IDLE, S_RUN}      p1_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO buffering port-1 read data for the output stream.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset (control only)
//   i_push, i_din write strobe and data
//   i_pop         read strobe; o_dout is the current head (show-ahead)
//   o_count       number of stored entries
//   o_empty       no entries stored
module sram_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != FULL);
  assign w_pop   = i_pop && (r_count != '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PONE;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CONE;
        2'b01:   r_count <= r_count - CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // The upstream credit scheme must never offer a word to a full FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_no_overflow: assert (!(i_push && (r_count == FULL)));
    end
  end

endmodule

// File: rtl/sram_wb_bridge.sv
// Wishbone-classic slave plus sequential read-stream engine in front of a
// 1RW/1R dual-port SRAM macro whose inputs are registered at posedge and
// whose dout changes at the following negedge.
// Ports:
//   wb_clk_i, wb_rst_i          clock (also both SRAM clocks), sync reset
//   wbs_*                       Wishbone slave, single-word, byte selects
//   rd_start_i/base_i/len_i     burst request; rd_busy_o while a burst runs
//   rd_valid_o/data_o/ready_i   burst output stream
//   sram_*0                     port 0 (read/write) of the macro
//   sram_*1                     port 1 (read only) of the macro
module sram_wb_bridge
  import sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = SRAM_ADDR_W,
  parameter int          DATA_WIDTH = SRAM_DATA_W,
  parameter int          NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  input  logic                  rd_start_i,
  input  logic [ADDR_WIDTH-1:0] rd_base_i,
  input  logic [ADDR_WIDTH:0]   rd_len_i,
  output logic                  rd_busy_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i,
  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_clk1,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int                    CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0]   MAX_LEN = (ADDR_WIDTH + 1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   LONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] AONE    = ADDR_WIDTH'(1);
  localparam logic [CNT_W:0]        CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  assign sram_clk0 = wb_clk_i;
  assign sram_clk1 = wb_clk_i;

  // Byte-offset bits carry no meaning for word accesses.
  logic w_unused_adr;
  assign w_unused_adr = &{1'b0, wbs_adr_i[1:0]};

  // ---------------- Port 0: Wishbone single-word access ----------------
  p0_state_t             r_p0_state, w_p0_next;
  logic [DATA_WIDTH-1:0] r_wb_dat;
  logic                  w_hit;

  assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign wbs_dat_o = r_wb_dat;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_p0_state <= IDLE;
    else          r_p0_state <= w_p0_next;
  end

  // Read data arrives one cycle after the request; capture it in RD_WAIT.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                   r_wb_dat <= '0;
    else if (r_p0_state == RD_WAIT) r_wb_dat <= sram_dout0;
  end

  always_comb begin
    w_p0_next   = r_p0_state;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    wbs_ack_o   = 1'b0;
    case (r_p0_state)
      IDLE: begin
        if (w_hit) begin
          sram_csb0   = 1'b0;
          sram_web0   = ~wbs_we_i;
          sram_wmask0 = wbs_sel_i;
          sram_addr0  = wbs_adr_i[ADDR_WIDTH+1:2];
          sram_din0   = wbs_dat_i;
          w_p0_next   = wbs_we_i ? ACK : RD_WAIT;
        end
      end
      RD_WAIT: w_p0_next = ACK;
      ACK: begin
        wbs_ack_o = 1'b1;
        w_p0_next = IDLE;
      end
      default: w_p0_next = IDLE;
    endcase
    // An access aborted by reset must neither reach the SRAM nor be acked.
    if (wb_rst_i) begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      wbs_ack_o   = 1'b0;
    end
  end

  // ---------------- Port 1: burst reader ----------------
  p1_state_t             r_p1_state, w_p1_next;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_rd_len;
  logic [ADDR_WIDTH:0]   r_iss_cnt;
  logic [ADDR_WIDTH:0]   r_pop_cnt;
  logic                  r_vld_p1;
  logic                  w_vld_p0;
  logic                  w_start_ok;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [CNT_W:0]        w_credit;

  assign w_start_ok = rd_start_i && (rd_len_i != '0) && (rd_len_i <= MAX_LEN);
  // Words already buffered plus the one read still on its way from the macro.
  assign w_credit   = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_vld_p1};
  assign rd_busy_o  = (r_p1_state == S_RUN);
  assign rd_valid_o = ~w_fifo_empty;
  assign w_pop      = rd_valid_o & rd_ready_i;
  assign sram_csb1  = ~w_vld_p0;
  assign sram_addr1 = w_vld_p0 ? r_rd_addr : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_p1_state <= S_IDLE;
    else          r_p1_state <= w_p1_next;
  end

  always_comb begin
    w_p1_next = r_p1_state;
    w_vld_p0  = 1'b0;
    case (r_p1_state)
      S_IDLE: if (w_start_ok) w_p1_next = S_RUN;
      S_RUN: begin
        w_vld_p0 = (r_iss_cnt < r_rd_len) && (w_credit < CREDITS);
        if (w_pop && (r_pop_cnt == r_rd_len - LONE)) w_p1_next = S_IDLE;
      end
      default: w_p1_next = S_IDLE;
    endcase
    if (wb_rst_i) w_vld_p0 = 1'b0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rd_addr <= '0;
      r_rd_len  <= '0;
      r_iss_cnt <= '0;
      r_pop_cnt <= '0;
    end else if ((r_p1_state == S_IDLE) && w_start_ok) begin
      r_rd_addr <= rd_base_i;
      r_rd_len  <= rd_len_i;
      r_iss_cnt <= '0;
      r_pop_cnt <= '0;
    end else begin
      // Address wraps naturally at the top of the array.
      if (w_vld_p0) begin
        r_rd_addr <= r_rd_addr + AONE;
        r_iss_cnt <= r_iss_cnt + LONE;
      end
      if (w_pop) r_pop_cnt <= r_pop_cnt + LONE;
    end
  end

  // ---- stage p0 -> p1: request registered by the macro ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= w_vld_p0;
  end

  // ---- stage p1 -> FIFO: dout valid since the negedge, captured here ----
  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (r_vld_p1),
    .i_din   (sram_dout1),
    .i_pop   (w_pop),
    .o_dout  (rd_data_o),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_sram_wb_bridge.sv
module tb_sram_wb_bridge;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] dat_o;
  logic        rd_start;
  logic [8:0]  rd_base;
  logic [9:0]  rd_len;
  logic        rd_busy, rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        sram_clk0, sram_clk1, sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  always #5 clk = ~clk;

  sram_wb_bridge #(.FIFO_DEPTH(FD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .rd_start_i(rd_start), .rd_base_i(rd_base), .rd_len_i(rd_len),
    .rd_busy_o(rd_busy), .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ready_i(rd_ready),
    .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0), .sram_clk1(sram_clk1), .sram_csb1(sram_csb1),
    .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  int vec  = 0;
  int miss = 0;
  int unsigned seed;
  logic [31:0] ref_mem [512];

  function automatic logic [31:0] init_word(int i, int unsigned s);
    return (32'(i) * 32'h9E37_79B9) ^ s;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] m);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // SRAM macro model: inputs registered at posedge, dout updated at negedge.
  logic [31:0] mem [512];
  bit          mem_loaded = 1'b0;
  logic        q_csb0 = 1'b1, q_web0 = 1'b1, q_csb1 = 1'b1;
  logic [3:0]  q_wmask0 = '0;
  logic [8:0]  q_addr0 = '0, q_addr1 = '0;
  logic [31:0] q_din0 = '0;
  logic [31:0] dout0_m = '0, dout1_m = '0;
  assign sram_dout0 = dout0_m;
  assign sram_dout1 = dout1_m;

  always @(posedge sram_clk0) begin
    q_csb0 <= sram_csb0; q_web0 <= sram_web0; q_wmask0 <= sram_wmask0;
    q_addr0 <= sram_addr0; q_din0 <= sram_din0;
    q_csb1 <= sram_csb1; q_addr1 <= sram_addr1;
  end

  always @(negedge sram_clk0) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i, seed);
      mem_loaded <= 1'b1;
    end else begin
      if (q_csb0 == 1'b0) begin
        if (q_web0 == 1'b0) begin
          for (int b = 0; b < 4; b++)
            if (q_wmask0[b]) mem[q_addr0][b*8 +: 8] <= q_din0[b*8 +: 8];
        end else begin
          dout0_m <= mem[q_addr0];
        end
      end
      if (q_csb1 == 1'b0) dout1_m <= mem[q_addr1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_idle();
    cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
  endtask

  // Drives one Wishbone access and reports what was seen; checks live in the callers.
  task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output int lat, output logic [31:0] rdata,
                           output logic o_csb, output logic [8:0] o_addr,
                           output logic [3:0] o_mask, output logic ack_after);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    #1;
    o_csb = sram_csb0; o_addr = sram_addr0; o_mask = sram_wmask0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ack === 1'b1) begin lat = c; break; end
    end
    rdata = dat_o;
    wb_idle();
    tick();
    ack_after = ack;
    if (w && a[31:11] == 21'h06_0000) ref_mem[a[10:2]] = merge(ref_mem[a[10:2]], d, s);
  endtask

  // Runs a burst and scores it against ref_mem. mode 0: ready high;
  // 1: ready 1 cycle on / 3 off; 2: random ready plus ignored restarts.
  task automatic run_burst(input int base, input int len, input int mode, input bit chk_lat);
    int issued = 0, popped = 0, first_v = -1, last_pop = -1;
    bit done = 0;
    rd_start = 1; rd_base = 9'(base); rd_len = 10'(len); rd_ready = (mode != 1);
    tick();
    rd_start = 0;
    for (int c = 1; c < len * 8 + 40; c++) begin
      rd_start = 0;
      case (mode)
        0: rd_ready = 1;
        1: rd_ready = (c % 4 == 0);
        default: begin
          rd_ready = ($urandom_range(0, 2) != 0);
          if (popped < len && $urandom_range(0, 4) == 0) begin
            rd_start = 1; rd_base = 9'($urandom); rd_len = 10'($urandom_range(1, 512));
          end
        end
      endcase
      if (popped == len) begin
        vec++;
        if (rd_busy !== 1'b0 || rd_valid !== 1'b0)
          $display("FAIL burst_done base=%0d: busy=%b valid=%b, required 0 0", base, rd_busy, rd_valid);
        if (rd_busy !== 1'b0 || rd_valid !== 1'b0) miss++;
        done = 1;
        break;
      end
      vec++;
      if (rd_busy !== 1'b1) begin
        miss++; $display("FAIL burst_busy cycle %0d: busy=%b, required 1", c, rd_busy);
      end
      if (sram_csb1 === 1'b0) begin
        vec++;
        if (sram_addr1 !== 9'((base + issued) % 512)) begin
          miss++;
          $display("FAIL burst_addr issue %0d: addr1=%0d, required %0d", issued, sram_addr1, (base + issued) % 512);
        end
        issued++;
      end
      vec++;
      if (issued - popped > FD) begin
        miss++; $display("FAIL burst_occupancy: outstanding=%0d, required <= %0d", issued - popped, FD);
      end
      if (rd_valid === 1'b1) begin
        if (first_v < 0) first_v = c;
        if (rd_ready) begin
          vec++;
          if (rd_data !== ref_mem[(base + popped) % 512]) begin
            miss++;
            $display("FAIL burst_data beat %0d: got %h, required %h", popped, rd_data, ref_mem[(base + popped) % 512]);
          end
          popped++;
          last_pop = c;
        end
      end
      tick();
    end
    rd_start = 0; rd_ready = 0;
    vec++;
    if (!done || issued != len) begin
      miss++; $display("FAIL burst_count base=%0d: issued=%0d popped=%0d, required %0d", base, issued, popped, len);
    end
    if (chk_lat) begin
      vec++;
      if (first_v != 3 || last_pop != 3 + len - 1) begin
        miss++;
        $display("FAIL burst_timing: first valid %0d last pop %0d, required 3 and %0d", first_v, last_pop, 3 + len - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0000; wdat = 32'h1234_5678;
    rd_start = 1; rd_base = 9'd3; rd_len = 10'd4; rd_ready = 1;
    tick(); tick(); tick();
    vec++;
    if (ack !== 0 || dat_o !== 0 || rd_busy !== 0 || rd_valid !== 0) begin
      miss++; $display("FAIL reset_out: ack=%b dat=%h busy=%b valid=%b, required 0", ack, dat_o, rd_busy, rd_valid);
    end
    vec++;
    if (sram_csb0 !== 1 || sram_web0 !== 1 || sram_wmask0 !== 0 || sram_addr0 !== 0 ||
        sram_csb1 !== 1 || sram_addr1 !== 0) begin
      miss++;
      $display("FAIL reset_sram: csb0=%b web0=%b wm=%h a0=%0d csb1=%b a1=%0d, required 1 1 0 0 1 0",
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_csb1, sram_addr1);
    end
    wb_idle(); rd_start = 0; rd_ready = 0;
    rst = 0;
    tick();
    vec++;
    if (rd_busy !== 0 || ack !== 0) begin
      miss++; $display("FAIL reset_release: busy=%b ack=%b, required 0 0", rd_busy, ack);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic csb, aa; logic [8:0] a0; logic [3:0] m;
    wb_access(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1, lat, rd, csb, a0, m, aa);
    vec++;
    if (lat != 1 || csb !== 0 || a0 !== 9'd4 || m !== 4'hF || aa !== 0) begin
      miss++;
      $display("FAIL wr_basic: lat=%0d csb0=%b addr0=%0d wmask0=%h ack_after=%b, required 1 0 4 f 0", lat, csb, a0, m, aa);
    end
    wb_access(32'h3000_0010, 32'h0, 4'h0, 0, lat, rd, csb, a0, m, aa);
    vec++;
    if (lat != 2 || rd !== 32'hDEAD_BEEF || aa !== 0) begin
      miss++; $display("FAIL rd_basic: lat=%0d data=%h ack_after=%b, required 2 deadbeef 0", lat, rd, aa);
    end
  endtask

  task automatic test_byte_mask();
    int lat; logic [31:0] rd; logic csb, aa; logic [8:0] a0; logic [3:0] m;
    wb_access(32'h3000_0125, 32'h1122_3344, 4'hF, 1, lat, rd, csb, a0, m, aa);
    wb_access(32'h3000_0126, 32'hAAAA_AAAA, 4'b0101, 1, lat, rd, csb, a0, m, aa);
    vec++;
    if (lat != 1 || m !== 4'b0101 || a0 !== 9'd73) begin
      miss++; $display("FAIL mask_wr: lat=%0d wmask0=%h addr0=%0d, required 1 5 73", lat, m, a0);
    end
    wb_access(32'h3000_0124, 32'h0, 4'h0, 0, lat, rd, csb, a0, m, aa);
    vec++;
    if (rd !== 32'h11AA_33AA) begin
      miss++; $display("FAIL mask_rd: got %h, required 11aa33aa", rd);
    end
    wb_access(32'h3000_0124, 32'h5555_5555, 4'h0, 1, lat, rd, csb, a0, m, aa);
    vec++;
    if (lat != 1 || csb !== 0 || m !== 4'h0) begin
      miss++; $display("FAIL sel0_wr: lat=%0d csb0=%b wmask0=%h, required 1 0 0", lat, csb, m);
    end
    wb_access(32'h3000_0124, 32'h0, 4'h0, 0, lat, rd, csb, a0, m, aa);
    vec++;
    if (rd !== 32'h11AA_33AA) begin
      miss++; $display("FAIL sel0_rd: got %h, required 11aa33aa", rd);
    end
  endtask

  task automatic test_out_of_window();
    cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = 32'h3000_0800; wdat = 32'hFFFF_FFFF;
    for (int c = 0; c < 20; c++) begin
      #1;
      vec++;
      if (sram_csb0 !== 1 || ack !== 0) begin
        miss++; $display("FAIL miss_window cycle %0d: csb0=%b ack=%b, required 1 0", c, sram_csb0, ack);
      end
      if (c == 10) begin we = 0; adr = 32'h2FFF_FFFC; end
      tick();
    end
    wb_idle();
    tick();
  endtask

  task automatic test_random_p0();
    int lat; logic [31:0] rd, a, d, expv; logic csb, aa, w; logic [8:0] a0; logic [3:0] m, s;
    for (int n = 0; n < 40; n++) begin
      a = 32'h3000_0000 | ($urandom_range(0, 511) << 2) | 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom); w = 1'($urandom);
      expv = ref_mem[a[10:2]];
      wb_access(a, d, s, w, lat, rd, csb, a0, m, aa);
      vec++;
      if (lat != (w ? 1 : 2) || a0 !== a[10:2] || (!w && rd !== expv)) begin
        miss++;
        $display("FAIL rand_p0 op %0d we=%b adr=%h: lat=%0d addr0=%0d data=%h, required lat %0d data %h",
                 n, w, a, lat, a0, rd, w ? 1 : 2, expv);
      end
    end
  endtask

  task automatic test_burst_wrap();
    run_burst(510, 4, 0, 1);
  endtask

  task automatic test_burst_backpressure();
    run_burst($urandom_range(0, 511), 16, 1, 0);
  endtask

  task automatic test_back_to_back();
    run_burst(100, 512, 0, 1);
    for (int n = 0; n < 3; n++) run_burst($urandom_range(0, 511), $urandom_range(1, 40), 2, 0);
  endtask

  task automatic test_reset_mid_op();
    rd_start = 1; rd_base = 9'($urandom); rd_len = 10'd64; rd_ready = 0;
    tick();
    rd_start = 0;
    for (int c = 0; c < 5; c++) tick();
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0040;
    tick();
    rst = 1; wb_idle();
    #1;
    vec++;
    if (ack !== 0) begin miss++; $display("FAIL rst_rdwait_ack: ack=%b, required 0", ack); end
    tick();
    vec++;
    if (ack !== 0 || dat_o !== 0 || rd_busy !== 0 || rd_valid !== 0 || sram_csb0 !== 1 ||
        sram_csb1 !== 1 || sram_web0 !== 1 || sram_wmask0 !== 0 || sram_addr0 !== 0 || sram_addr1 !== 0) begin
      miss++;
      $display("FAIL rst_mid: ack=%b dat=%h busy=%b valid=%b csb0=%b csb1=%b, required 0 0 0 0 1 1",
               ack, dat_o, rd_busy, rd_valid, sram_csb0, sram_csb1);
    end
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vec++;
      if (ack !== 0 || rd_valid !== 0) begin
        miss++; $display("FAIL rst_after cycle %0d: ack=%b valid=%b, required 0 0", c, ack, rd_valid);
      end
    end
    for (int k = 0; k < 2; k++) begin
      rd_start = 1; rd_base = 9'd5; rd_len = (k == 0) ? 10'd0 : 10'd600;
      tick();
      rd_start = 0;
      for (int c = 0; c < 3; c++) begin
        vec++;
        if (rd_busy !== 0 || sram_csb1 !== 1) begin
          miss++; $display("FAIL bad_len %0d: busy=%b csb1=%b, required 0 1", rd_len, rd_busy, sram_csb1);
        end
        tick();
      end
    end
    run_burst(7, 5, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = $urandom;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i, seed);
    rst = 1; wb_idle(); rd_start = 0; rd_base = '0; rd_len = '0; rd_ready = 0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_out_of_window();
    test_random_p0();
    test_burst_wrap();
    test_burst_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
